// File: rtl/act_interp_pkg.sv
// act_pkg: shared widths, saturation limits and activation table contents
package act_pkg;
  localparam int DATA_W_D = 8;
  localparam int ADDR_W_D = 4;
  localparam int FRAC_W_D = DATA_W_D - ADDR_W_D;
  function automatic int sat_hi(int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int sat_lo(int w);
    return -(1 << (w - 1));
  endfunction
  // identity-slope table: upper half of the index range maps to negative samples
  function automatic int lut_entry(int i, int addr_w, int frac_w);
    return (i < (1 << (addr_w - 1))) ? (i << frac_w) : (i << frac_w) - (1 << (addr_w + frac_w));
  endfunction
endpackage

// File: rtl/act_interp_if.sv
// act_interp_if: sample-in / result-out handshake bundle
interface act_interp_if
  import act_pkg::*;
#(
  parameter int DATA_W = DATA_W_D
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] y_out;
  modport slave (input in_valid, x_in, out_ready, output in_ready, out_valid, y_out);
  modport master (output in_valid, x_in, out_ready, input in_ready, out_valid, y_out);
endinterface

// File: rtl/act_interp_lut.sv
// act_lut: combinational activation table read of base and next entry
module act_lut
  import act_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int FRAC_W = FRAC_W_D
) (
  input  logic [ADDR_W-1:0]        i_addr,
  output logic signed [DATA_W-1:0] o_base,
  output logic signed [DATA_W-1:0] o_next_data
);
  localparam logic [ADDR_W-1:0] TOP_POS = {1'b0, {(ADDR_W-1){1'b1}}};
  logic signed [DATA_W-1:0] w_tab [2**ADDR_W];
  logic [ADDR_W-1:0]        w_next_addr;
  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_tab
    assign w_tab[i] = DATA_W'(lut_entry(i, ADDR_W, FRAC_W));
  end
  // next entry wraps from the last index to 0, but clamps at the most positive index
  always_comb begin
    w_next_addr = (i_addr == TOP_POS) ? i_addr : i_addr + ADDR_W'(1);
    o_base      = w_tab[i_addr];
    o_next_data = w_tab[w_next_addr];
  end
endmodule

// File: rtl/act_interp.sv
// act_interp: 3-stage piecewise-linear activation with saturation and stall
module act_interp
  import act_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input logic         clk,
  input logic         rst,
  act_interp_if.slave bus
);
  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam logic signed [DATA_W:0] Y_HI = (DATA_W+1)'(sat_hi(DATA_W));
  localparam logic signed [DATA_W:0] Y_LO = (DATA_W+1)'(sat_lo(DATA_W));
  logic                         w_en;
  logic                         r_v1, r_v2, r_ov;
  logic [ADDR_W-1:0]            r_addr;
  logic [FRAC_W-1:0]            r_frac1, r_frac2;
  logic signed [DATA_W-1:0]     r_base, r_next, r_y;
  logic signed [DATA_W-1:0]     w_base, w_next, w_y;
  logic signed [DATA_W:0]       w_diff, w_sum;
  logic signed [DATA_W+FRAC_W:0] w_prod;
  assign w_en          = !r_ov || bus.out_ready;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_ov;
  assign bus.y_out     = r_y;
  act_lut #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .FRAC_W (FRAC_W)
  ) u_lut (
    .i_addr      (r_addr),
    .o_base      (w_base),
    .o_next_data (w_next)
  );
  // interpolate between table entries, then clamp to the sample range
  always_comb begin
    w_diff = {r_next[DATA_W-1], r_next} - {r_base[DATA_W-1], r_base};
    w_prod = w_diff * $signed({1'b0, r_frac2});
    w_sum  = {r_base[DATA_W-1], r_base} + (DATA_W+1)'(w_prod >>> FRAC_W);
    w_y    = (w_sum > Y_HI) ? Y_HI[DATA_W-1:0] : (w_sum < Y_LO) ? Y_LO[DATA_W-1:0] : w_sum[DATA_W-1:0];
  end
  // valid chain and result register; reset discards anything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_ov <= 1'b0;
      r_y  <= '0;
    end else if (w_en) begin
      r_v1 <= bus.in_valid;
      r_v2 <= r_v1;
      r_ov <= r_v2;
      r_y  <= w_y;
    end
  end
  // data stages follow the same enable; their contents are qualified by the valid chain
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_addr  <= bus.x_in[DATA_W-1:FRAC_W];
      r_frac1 <= bus.x_in[FRAC_W-1:0];
      r_base  <= w_base;
      r_next  <= w_next;
      r_frac2 <= r_frac1;
    end
  end
endmodule
